// File: rtl/mod3_pkg.sv
// Shared types and helpers for the serial mod-3 checker.
// Optional build macro MOD3_COUNT_EN (used by mod3_serial_checker) adds the
// divisible-result counter; COUNT_W sizes it.
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [1:0] rem_t;

  localparam int COUNT_W = 16;

  // One MSB-first step: (2*rem + data_bit) mod 3 as a small lookup,
  // so no adder, multiplier or divider is needed.
  function automatic rem_t mod3_step(input rem_t rem, input logic data_bit);
    rem_t res;
    res = 2'd0;
    case (rem)
      2'd0:    res = data_bit ? 2'd1 : 2'd0;
      2'd1:    res = data_bit ? 2'd0 : 2'd2;
      2'd2:    res = data_bit ? 2'd2 : 2'd1;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mod3_bit_step.sv
// Combinational remainder step: folds one new bit into a running mod-3 value.
module mod3_bit_step
  import mod3_pkg::*;
(
  input  rem_t rem,
  input  logic data_bit,
  output rem_t rem_next
);

  // Pure lookup; the incoming rem is always in 0..2.
  always_comb begin
    rem_next = mod3_step(rem, data_bit);
  end

endmodule

// File: rtl/mod3_serial_checker.sv
// Serial mod-3 checker: accepts an unsigned operand, walks it MSB-first one
// bit per cycle, and reports the remainder, a divisible flag and a vector of
// prefix divisibility flags (bit k covers in_data[WIDTH-1 : WIDTH-1-k]).
// Optional build macro MOD3_COUNT_EN adds div_count, a saturating count of
// divisible results consumed downstream.
module mod3_serial_checker
  import mod3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         remainder,
  output logic               divisible,
`ifdef MOD3_COUNT_EN
  output logic [COUNT_W-1:0] div_count,
`endif
  output logic [WIDTH-1:0]   prefix_div
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  rem_t               rem_q;
  rem_t               rem_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   shadow;
  logic [WIDTH-1:0]   shadow_next;

  mod3_bit_step u_step (
    .rem      (rem_q),
    .data_bit (shreg[WIDTH-1]),
    .rem_next (rem_next)
  );

  // Prefix flags enter at the MSB and shift right, so the flag from the
  // first processed bit ends up in bit 0 after WIDTH steps.
  always_comb begin
    shadow_next = {(rem_next == 2'd0), shadow[WIDTH-1:1]};
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      remainder  <= 2'd0;
      divisible  <= 1'b0;
      prefix_div <= '0;
      shreg      <= '0;
      rem_q      <= 2'd0;
      cnt        <= '0;
      shadow     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            rem_q    <= 2'd0;
            shadow   <= '0;
            cnt      <= CNT_W'(WIDTH);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          rem_q  <= rem_next;
          shadow <= shadow_next;
          shreg  <= {shreg[WIDTH-2:0], 1'b0};
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            remainder  <= rem_next;
            divisible  <= (rem_next == 2'd0);
            prefix_div <= shadow_next;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD3_COUNT_EN
  // Count consumed divisible results, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_count <= '0;
    end else if (out_valid && out_ready && divisible && (div_count != '1)) begin
      div_count <= div_count + COUNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mod3_serial_checker.sv
// Directed bench for mod3_serial_checker (WIDTH = 8).
module tb_mod3_serial_checker;
  import mod3_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       remainder;
  logic             divisible;
  logic [WIDTH-1:0] prefix_div;
`ifdef MOD3_COUNT_EN
  logic [COUNT_W-1:0] div_count;
`endif

  int checks   = 0;
  int failures = 0;

  mod3_serial_checker #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .remainder  (remainder),
    .divisible  (divisible),
`ifdef MOD3_COUNT_EN
    .div_count  (div_count),
`endif
    .prefix_div (prefix_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Present an operand, wait for acceptance, then measure latency to out_valid.
  // in_valid stays high with different data during SHIFT to show it is ignored.
  task automatic start_op(input logic [7:0] d, input string tag);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_data = ~d;
    chk({tag, "_busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
      if (n == 3) in_data = 8'h5A;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, n, WIDTH);
  endtask

  task automatic chk_result(input string tag, input logic [1:0] erem, input logic [7:0] epre);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_rem"}, remainder, erem);
    chk({tag, "_div"}, divisible, (erem == 2'd0));
    chk({tag, "_prefix"}, prefix_div, epre);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  task automatic full_op(input logic [7:0] d, input logic [1:0] erem, input logic [7:0] epre,
                         input string tag);
    start_op(d, tag);
    chk_result(tag, erem, epre);
    finish_op(tag);
  endtask

  initial begin
    int pulses;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_div", divisible, 0);
    chk("rst_prefix", prefix_div, 0);

    // Reset mid-run after two shifts, then operand 0
    in_data = 8'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst1_in_ready", in_ready, 1);
    chk("rst1_out_valid", out_valid, 0);
    full_op(8'd0, 2'd0, 8'hFF, "op0");

    // Main function
    full_op(8'd6,   2'd0, 8'hDF, "op6");
    full_op(8'd7,   2'd1, 8'h5F, "op7");
    full_op(8'd100, 2'd1, 8'h1D, "op100");
    full_op(8'd255, 2'd0, 8'hAA, "op255");
    full_op(8'd45,  2'd0, 8'h83, "op45");
    full_op(8'd96,  2'd0, 8'hFD, "op96");

    // Backpressure: results held and in_ready low while out_ready is 0
    start_op(8'd7, "bp");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_rem", remainder, 1);
      chk("bp_hold_prefix", prefix_div, 8'h5F);
    end
    finish_op("bp");
    chk("idle_keep_rem", remainder, 1);
    chk("idle_keep_prefix", prefix_div, 8'h5F);

    // Reset on the 4th SHIFT edge discards the operand
    in_data = 8'd255; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_rem", remainder, 0);
    pulses = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("rst2_no_pulse", pulses, 0);
    full_op(8'd9, 2'd0, 8'h8F, "op9");

    // Reset while in DONE drops out_valid, with out_ready high at the same edge
    start_op(8'd7, "rstd");
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    chk("rstd_out_valid", out_valid, 0);
    chk("rstd_in_ready", in_ready, 1);
    chk("rstd_rem", remainder, 0);

`ifdef MOD3_COUNT_EN
    chk("cnt_reset", div_count, 0);
    full_op(8'd0,   2'd0, 8'hFF, "c0");
    full_op(8'd6,   2'd0, 8'hDF, "c6");
    full_op(8'd7,   2'd1, 8'h5F, "c7");
    full_op(8'd45,  2'd0, 8'h83, "c45");
    full_op(8'd96,  2'd0, 8'hFD, "c96");
    full_op(8'd100, 2'd1, 8'h1D, "c100");
    full_op(8'd255, 2'd0, 8'hAA, "c255");
    chk("cnt_seq", div_count, 5);
    force dut.div_count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.div_count;
    full_op(8'd0, 2'd0, 8'hFF, "s0");
    chk("cnt_fffe_plus1", div_count, 16'hFFFF);
    full_op(8'd6, 2'd0, 8'hDF, "s6");
    chk("cnt_sat", div_count, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
